// File: rtl/bitscan_encoder8to3.sv
// Sequential 8-to-3 bit-scan encoder.
// Captures a multi-hot vector and emits the index of each set bit,
// lowest first, one beat per accepted valid/ready handshake.
module bitscan_encoder8to3 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] vec_in,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IDX_W:0]   remaining,
    output logic             zero_flag
);

    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_nxt;
    logic             zero_nxt;
    logic             found;

    // Priority-encode the lowest pending bit and count pending bits.
    always_comb begin
        out_index = '0;
        remaining = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (pend[i] && !found) begin
                out_index = IDX_W'(i);
                found     = 1'b1;
            end
            remaining = remaining + CNT_W'(pend[i]);
        end
    end

    // Handshake qualifiers are gated by en so a frozen block cannot transfer.
    always_comb begin
        in_ready  = en && (state == ST_IDLE);
        out_valid = en && (state == ST_SCAN);
        out_last  = (remaining == CNT_W'(1));
    end

    // Next-state logic: capture in IDLE, retire one bit per beat in SCAN.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        zero_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load && in_ready) begin
                    if (vec_in != '0) begin
                        pend_nxt  = vec_in;
                        state_nxt = ST_SCAN;
                    end else begin
                        zero_nxt  = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        pend_nxt  = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        pend_nxt  = pend & ~(WIDTH'(1) << out_index);
                    end
                end
            end
            default: begin
                pend_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pending vector and zero-load pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pend      <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            zero_flag <= zero_nxt;
        end
    end

endmodule

// File: tb/tb_bitscan_encoder8to3.sv
// Self-checking bench for bitscan_encoder8to3 using an expected-beat queue.
module tb_bitscan_encoder8to3;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic [3:0] rem;
    } beat_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] vec_in;
    logic       in_ready;
    logic [2:0] out_index;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [3:0] remaining;
    logic       zero_flag;

    beat_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_beats  = 0;
    int    cyc;

    bitscan_encoder8to3 dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .vec_in    (vec_in),
        .in_ready  (in_ready),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .remaining (remaining),
        .zero_flag (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected beats for a vector: ascending indices with countdown of remaining.
    task automatic push_vec(input logic [7:0] v);
        int    rem;
        beat_t b;
        rem = $countones(v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                b.idx  = 3'(i);
                b.rem  = 4'(rem);
                b.last = (rem == 1);
                q.push_back(b);
                rem--;
            end
        end
    endtask

    // Sample outputs, score any accepted beat, then advance one clock.
    task automatic cycle();
        beat_t e;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                e = q.pop_front();
                n_beats++;
                chk("index", out_index, e.idx);
                chk("last", out_last, e.last);
                chk("remaining", remaining, e.rem);
            end
        end else if (out_valid && q.size() != 0) begin
            chk("hold_index", out_index, q[0].idx);
        end
        @(posedge clk);
        #1;
    endtask

    // Run until the expected queue empties; optionally toggle out_ready 1,0,1...
    task automatic drain(input bit toggle, output int cycles);
        cycles = 0;
        while (q.size() != 0 && cycles < 100) begin
            out_ready = toggle ? (cycles % 2 == 0) : 1'b1;
            #1;
            chk("valid_scan", out_valid, 1);
            chk("in_ready_scan", in_ready, 0);
            cycle();
            cycles++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load   = 1'b1;
        vec_in = v;
        #1;
        chk("in_ready_idle", in_ready, 1);
        if (v != 8'h00) push_vec(v);
        cycle();
        load   = 1'b0;
        vec_in = 8'h00;
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        load      = 1'b0;
        vec_in    = 8'h00;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_index", out_index, 0);
        chk("rst_last", out_last, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_zero_flag", zero_flag, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic scan of 1010_0100: 2,5,7 on consecutive cycles.
        do_load(8'b1010_0100);
        chk("valid_after_load", out_valid, 1);
        drain(1'b0, cyc);
        chk("a4_cycles", cyc, 3);
        #1;
        chk("a4_idle_valid", out_valid, 0);
        chk("a4_idle_in_ready", in_ready, 1);

        // Zero vector: one-cycle pulse, stays idle.
        do_load(8'h00);
        chk("zero_pulse", zero_flag, 1);
        chk("zero_valid", out_valid, 0);
        chk("zero_in_ready", in_ready, 1);
        cycle();
        chk("zero_clear", zero_flag, 0);
        chk("zero_valid2", out_valid, 0);
        chk("zero_in_ready2", in_ready, 1);

        // All ones with out_ready toggling: 8 beats over 15 cycles.
        n_beats = 0;
        do_load(8'hFF);
        drain(1'b1, cyc);
        chk("ff_beats", n_beats, 8);
        chk("ff_cycles", cyc, 15);
        out_ready = 1'b1;
        #1;
        chk("ff_idle", out_valid, 0);

        // Enable gap after first beat of 8'h81.
        do_load(8'h81);
        cycle();
        chk("81_first_popped", q.size(), 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("gap_valid", out_valid, 0);
            chk("gap_remaining", remaining, 1);
            chk("gap_in_ready", in_ready, 0);
            cycle();
        end
        en = 1'b1;
        drain(1'b0, cyc);
        chk("81_resume_cycles", cyc, 1);

        // Asynchronous reset mid-scan of 8'h3C after index 2.
        do_load(8'h3C);
        cycle();
        chk("3c_after_first", q.size(), 3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_remaining", remaining, 0);
        q.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_load(8'h01);
        drain(1'b0, cyc);
        chk("01_cycles", cyc, 1);

        // Load held high during a scan of 8'h06 must be ignored.
        do_load(8'h06);
        load   = 1'b1;
        vec_in = 8'hF0;
        drain(1'b0, cyc);
        load   = 1'b0;
        vec_in = 8'h00;
        chk("06_cycles", cyc, 2);
        #1;
        chk("06_idle_valid", out_valid, 0);
        chk("06_idle_remaining", remaining, 0);
        cycle();
        chk("06_no_extra", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bitscan_encoder8to3.md
Name: bitscan_encoder8to3

Overview:
- Sequential 8-to-3 encoder; the inverse of the ALU's 3-to-8 one-hot decoders.
- Captures an 8-bit multi-hot vector, then emits the 3-bit index of each set bit, one per beat, lowest index first.
- Uses a valid/ready handshake on the output side.
- Sits between the ALU status/flag vectors and the control unit, which consumes indices serially (e.g. to re-drive the 3-to-8 decoders).

Parameters:
- WIDTH, 8, input vector width; fixed at 8 for this block.
- IDX_W, 3, index width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  global enable. When 0: all handshakes are blocked and all state is held.
- load  input  1  request to capture vec_in.
- vec_in  input  8  vector to encode; bit i set means index i is pending.
- in_ready  output  1  block can accept load; equals en AND (state==IDLE).
- out_index  output  3  index of the lowest pending bit.
- out_valid  output  1  out_index is valid; equals en AND (state==SCAN).
- out_ready  input  1  consumer accepts out_index this cycle.
- out_last  output  1  current beat is the final pending bit; only meaningful with out_valid.
- remaining  output  4  popcount of the pending register (0..8).
- zero_flag  output  1  one-cycle registered pulse: a load of an all-zero vector was accepted.

Behaviour:
- One clock domain, two states: IDLE, SCAN. Registered state: fsm state, pend[7:0], zero_flag.
- Async reset: state=IDLE, pend=0, zero_flag=0. While reset is asserted, out_valid=0, out_index=0, out_last=0, remaining=0, and in_ready=en.
- out_index, out_last, remaining and in_ready are combinational from registered state and en. No combinational path from vec_in or out_ready to any output.
- out_index is the priority encode (lowest set bit) of pend. It is 0 when pend==0.
- out_last = (remaining==1).
- IDLE, load&&in_ready, vec_in!=0: pend<=vec_in; next state SCAN; zero_flag<=0.
- IDLE, load&&in_ready, vec_in==0: stay in IDLE; zero_flag<=1 for exactly one cycle; pend stays 0.
- IDLE, no accepted load: zero_flag<=0.
- SCAN, out_valid&&out_ready: clear bit out_index in pend.
  - If out_last, next state is IDLE and pend becomes 0.
  - Otherwise stay in SCAN.
- SCAN, !out_ready: hold pend and out_index stable (AXI-style; valid never drops without acceptance, except via en=0 or reset).
- load is ignored in SCAN; in_ready=0 there. No queuing.
- Latency and throughput:
  - load accepted at edge N: out_valid=1 in the cycle after edge N.
  - With out_ready held at 1, a vector with k set bits takes exactly k beats.
  - After the last beat there is one IDLE cycle before the next load can be accepted, so the minimum period is k+1 cycles.
- en=0: state, pend and zero_flag are frozen; in_ready=0; out_valid=0. Deasserting en mid-scan resumes at the same index when en returns.
- zero_flag is cleared on the cycle following its pulse regardless of en.
- Reset mid-scan: aborts immediately (asynchronously); pending bits are discarded.

Test Plan:
- Reset, en=1, load vec_in=8'b1010_0100, out_ready=1:
  - out_index sequence 2,5,7 on three consecutive cycles.
  - remaining 3,2,1.
  - out_last=1 only on index 7.
  - Then in_ready=1 one cycle later.
- Load 8'h00 in IDLE: zero_flag=1 for exactly one cycle; out_valid stays 0; state remains IDLE.
- Load 8'hFF with out_ready toggling 1,0,1,0...: indices 0..7 in order; each index is held stable while out_ready=0; 8 accepted beats total.
- Load 8'h81, drop en for 3 cycles after the first accepted beat (index 0):
  - out_valid=0 and remaining holds at 1 during the gap.
  - Index 7 with out_last=1 is emitted after en returns.
- Mid-scan reset (after loading 8'h3C and accepting index 2): reset asserted asynchronously, between clock edges, immediately gives out_valid=0 and remaining=0; after release, a new load of 8'h01 yields index 0 with out_last=1.
- Load asserted during SCAN with vec_in=8'hF0 while scanning 8'h06: ignored; only indices 1,2 are emitted.
